// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Microsequencer for the dual-stack datapath (stacks A/B, ALU, data-in mux,
// stackb/storeb holding registers and the `great` comparator). It takes one
// instruction at a time over a valid/ready handshake. It checks the stack
// pointers for overflow/underflow, then drives the push/pop, ALU, mux-select
// and load strobes. It reports completion and errors.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   instr_valid/ready     instruction handshake; ready only while idle
//   instr_op, instr_mode  opcode and ALU function bits, latched on accept
//   pointerA, pointerB    stack occupancies (DEPTH = full, 0 = empty)
//   great                 comparator result, captured by CMP into cmp_flag
//   pushA/popA/pushB/popB stack strobes
//   alu_a, alu_b, alu_c   ALU function select and write-back strobe
//   load_e                storeb_reg load strobe
//   d_select              mux: 0 data_in, 1 top, 2 stackb_reg, 3 storeb_reg
//   done, err             one-cycle completion / error pulses
//   err_code              last error (0 none, 1 ovf, 2 unf, 3 illegal op)
//   cmp_flag              `great` as sampled by the last CMP
// -----------------------------------------------------------------------------
module stack_ctrl #(
  parameter int DEPTH   = 16,
  parameter int PW      = 5,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [1:0]    instr_mode,
  input  logic [PW-1:0] pointerA,
  input  logic [PW-1:0] pointerB,
  input  logic          great,
  output logic          pushA,
  output logic          popA,
  output logic          pushB,
  output logic          popB,
  output logic          alu_a,
  output logic          alu_b,
  output logic          alu_c,
  output logic          load_e,
  output logic [1:0]    d_select,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          cmp_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, WB} state_t;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_PUSHA   = 4'd1,
    OP_PUSHB   = 4'd2,
    OP_POPA    = 4'd3,
    OP_POPB    = 4'd4,
    OP_DUPA    = 4'd5,
    OP_ALU     = 4'd6,
    OP_STORE_E = 4'd7,
    OP_XFER_B  = 4'd8,
    OP_XFER_S  = 4'd9,
    OP_CMP     = 4'd10
  } op_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UNF, ERR_ILL} err_t;

  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_TWO  = PW'(2);
  // WAIT counts down from ALU_LAT-1 to 0, giving exactly ALU_LAT cycles.
  localparam logic [2:0]    LAT_M1   = 3'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

  state_t     state, state_next;
  logic [3:0] op_q;
  logic [1:0] mode_q;
  logic [2:0] wait_cnt;
  err_t       chk_code;

  assign instr_ready = (state == IDLE);

  // Pointer checks for the latched op. Only meaningful while in EXEC.
  // Underflow is tested before overflow, so DUP_A on an empty stack
  // reports underflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would otherwise infer a latch.
    chk_code = ERR_NONE;
    case (op_q)
      OP_NOP, OP_STORE_E, OP_CMP: chk_code = ERR_NONE;
      OP_PUSHA, OP_XFER_B, OP_XFER_S:
        if (pointerA == PTR_FULL) chk_code = ERR_OVF;
      OP_PUSHB:
        if (pointerB == PTR_FULL) chk_code = ERR_OVF;
      OP_POPA:
        if (pointerA == '0) chk_code = ERR_UNF;
      OP_POPB:
        if (pointerB == '0) chk_code = ERR_UNF;
      OP_DUPA:
        if (pointerA == '0)            chk_code = ERR_UNF;
        else if (pointerA == PTR_FULL) chk_code = ERR_OVF;
      OP_ALU:
        if (pointerA < PTR_TWO) chk_code = ERR_UNF;
      default: chk_code = ERR_ILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and strobe decode. Strobes depend only on the registered
  // state, the latched op/mode and (in EXEC) the pointer check, never on
  // instr_*.
  always_comb begin
    state_next = state;
    pushA      = 1'b0;
    popA       = 1'b0;
    pushB      = 1'b0;
    popB       = 1'b0;
    alu_a      = 1'b0;
    alu_b      = 1'b0;
    alu_c      = 1'b0;
    load_e     = 1'b0;
    d_select   = 2'd0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        if (instr_valid) state_next = EXEC;
      end

      EXEC: begin
        state_next = IDLE;
        if (chk_code != ERR_NONE) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          case (op_q)
            OP_PUSHA:   begin pushA = 1'b1; d_select = 2'd0; done = 1'b1; end
            OP_PUSHB:   begin pushB = 1'b1; d_select = 2'd0; done = 1'b1; end
            OP_POPA:    begin popA  = 1'b1; done = 1'b1; end
            OP_POPB:    begin popB  = 1'b1; done = 1'b1; end
            OP_DUPA:    begin pushA = 1'b1; d_select = 2'd1; done = 1'b1; end
            OP_STORE_E: begin load_e = 1'b1; done = 1'b1; end
            OP_XFER_B:  begin pushA = 1'b1; d_select = 2'd2; done = 1'b1; end
            OP_XFER_S:  begin pushA = 1'b1; d_select = 2'd3; done = 1'b1; end
            OP_ALU: begin
              // Second operand is popped now; the result overwrites the top
              // of A when alu_c fires in WB.
              alu_a      = mode_q[1];
              alu_b      = mode_q[0];
              popA       = 1'b1;
              state_next = (ALU_LAT == 0) ? WB : WAIT;
            end
            default: done = 1'b1;  // NOP, CMP
          endcase
        end
      end

      WAIT: begin
        if (wait_cnt == 3'd0) state_next = WB;
      end

      WB: begin
        alu_c      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Latched instruction, ALU wait counter, error code and comparator flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 4'd0;
      mode_q   <= 2'd0;
      wait_cnt <= 3'd0;
      err_code <= 2'd0;
      cmp_flag <= 1'b0;
    end else begin
      if (state == IDLE && instr_valid) begin
        op_q     <= instr_op;
        mode_q   <= instr_mode;
        err_code <= 2'd0;
      end
      if (state == EXEC) begin
        wait_cnt <= LAT_M1;
        if (chk_code != ERR_NONE) err_code <= chk_code;
        else if (op_q == OP_CMP)  cmp_flag <= great;
      end
      if (state == WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
    end
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Microsequencer for the dual-stack datapath: stacks A/B, ALU, data-in mux, stackb/storeb holding registers and the `great` comparator.
- Accepts one instruction at a time over a valid/ready handshake.
- Checks stack pointers for overflow/underflow, then drives the single-cycle push/pop, ALU, mux-select and load strobes in the correct order.
- Reports completion and errors, and captures the comparator result.

Parameters:
- DEPTH, 16, stack capacity in entries; a pointer equal to DEPTH means full, 0 means empty.
- PW, 5, pointer width; must satisfy 2^PW > DEPTH.
- ALU_LAT, 1, wait cycles between ALU strobe and result write-back (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr_op  in  4  opcode.
- instr_mode  in  2  ALU function bits for the ALU op.
- pointerA  in  PW  stack A occupancy.
- pointerB  in  PW  stack B occupancy.
- great  in  1  comparator (stackb_reg < storeb_reg).
- pushA, popA, pushB, popB  out  1 each  stack strobes.
- alu_a, alu_b  out  1 each  ALU function select.
- alu_c  out  1  ALU write-back / stackb_reg load strobe.
- load_e  out  1  storeb_reg load strobe.
- d_select  out  2  mux select: 0 = data_in, 1 = top, 2 = stackb_reg, 3 = storeb_reg.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- err_code  out  2  last error: 0 none, 1 overflow, 2 underflow, 3 illegal op; held until next accept or rst.
- cmp_flag  out  1  registered copy of `great` from the last CMP.

Behaviour:
- States: IDLE, EXEC, WAIT, WB. The FSM state, latched op/mode, cmp_flag and err_code are registered. Strobes, d_select, done and err are decoded from the registered state and latched op only; there is no combinational path from instr_* to the strobes.
- Reset values: state IDLE; every strobe 0; d_select 0; done 0; err 0; err_code 0; cmp_flag 0. instr_ready is 1 in the cycle after rst deasserts.
- instr_ready = (state == IDLE). An instruction is accepted on a rising edge where instr_valid & instr_ready. On accept, op/mode are latched, err_code is cleared and the FSM goes to EXEC. instr_valid while not ready is ignored; it is not queued.
- Pointer checks use pointerA/pointerB values sampled in EXEC. A failing check suppresses every strobe, asserts done+err, sets err_code, and returns the FSM to IDLE.
- Opcodes, all executed in EXEC:
  - 0 NOP: done, no strobe.
  - 1 PUSHA_IMM: d_select 0, pushA. Overflow if pointerA == DEPTH.
  - 2 PUSHB_IMM: d_select 0, pushB. Overflow if pointerB == DEPTH.
  - 3 POPA: popA. Underflow if pointerA == 0.
  - 4 POPB: popB. Underflow if pointerB == 0.
  - 5 DUP_A: d_select 1, pushA. Underflow if pointerA == 0; otherwise overflow if pointerA == DEPTH.
  - 6 ALU: requires pointerA >= 2, else underflow. EXEC drives alu_a = mode[1], alu_b = mode[0], popA for 1 cycle. Then WAIT for ALU_LAT cycles with all strobes 0 (skipped if ALU_LAT == 0). Then WB drives alu_c for 1 cycle plus done.
  - 7 STORE_E: load_e, done.
  - 8 XFER_B: d_select 2, pushA. Overflow check on A.
  - 9 XFER_S: d_select 3, pushA. Overflow check on A.
  - 10 CMP: cmp_flag <= great at the EXEC edge; done.
  - 11-15: illegal op, err_code 3.
- Latency: a single-cycle op accepted at edge N has its strobe and done high during cycle N+1, and instr_ready is high again in N+2. ALU done comes ALU_LAT+1 cycles after EXEC.
- Throughput: one instruction per 2 cycles at best.
- Invariants:
  - Never pushX together with popX.
  - At most one of pushA/pushB/popA/popB, except that ALU EXEC asserts popA alone.
  - alu_c and load_e are never asserted together.
  - d_select holds its value for the whole strobe cycle and is 0 otherwise.
- Reset mid-operation (any state): next edge returns to IDLE with all strobes 0. No done is issued for the aborted instruction.

Test Plan:
- Reset, then PUSHA_IMM with pointerA = 3 → pushA = 1 and d_select = 0 for exactly 1 cycle, done coincident, instr_ready high 2 cycles after accept.
- PUSHA_IMM with pointerA = 16 (DEPTH = 16) → no pushA, done = err = 1, err_code = 1; POPB with pointerB = 0 → err_code = 2.
- ALU, mode = 2'b10, pointerA = 4, ALU_LAT = 2 → EXEC: alu_a = 1, alu_b = 0, popA; 2 idle cycles; WB: alu_c = 1 and done; 4 cycles accept-to-done.
- ALU with pointerA = 1 → underflow, no alu_a/alu_b/alu_c/popA; opcode 13 → err_code 3.
- CMP with great = 1 → cmp_flag = 1; CMP with great = 0 → cmp_flag = 0. XFER_S → d_select = 3 with pushA.
- Assert rst during WAIT of an ALU op → no alu_c or done, all outputs at reset values next cycle; a following NOP completes normally.
